// File: rtl/load_unit.sv
`default_nettype none
// load_unit: MIPS-style load formatter (LB/LH/LW/LBU/LHU/LWL/LWR) issuing one memory read per request.
// Define LOAD_UNIT_ALIGN_TRAP_EN to trap misaligned LH/LHU/LW loads instead of silently aligning them.
module load_unit #(
   parameter int BYTE_SWAP  = 1,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           rt_in,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           result,
   output logic                  addr_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic [3:0]            mem_byteenable,
   input  logic                  mem_waitrequest,
   input  logic [31:0]           mem_readdata
);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LWL = 3'b010;
   localparam logic [2:0] OP_LW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_LWR = 3'b110;
   localparam logic [2:0] OP_LW2 = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              op_q, op_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             rt_q, rt_d;
   logic [31:0]             result_q, result_d;

   logic                    in_half, in_word, trap;
   logic [ADDR_WIDTH-1:0]   addr_fix;
   logic [31:0]             word_w, load_val;
   logic [1:0]              k;
   logic [4:0]              sh_l, sh_r;
   logic [7:0]              byte_v;
   logic [15:0]             half_v;
   logic [3:0]              be;

   // Low address bits that would make the access misaligned are cleared at capture time.
   always_comb begin
      in_half  = (op == OP_LH) || (op == OP_LHU);
      in_word  = (op == OP_LW) || (op == OP_LW2);
      addr_fix = addr;
      if (in_word) begin
         addr_fix[1:0] = 2'b00;
      end else if (in_half) begin
         addr_fix[0] = 1'b0;
      end
   end

`ifdef LOAD_UNIT_ALIGN_TRAP_EN
   assign trap = (in_half && addr[0]) || (in_word && (addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      word_w = (BYTE_SWAP != 0)
             ? {mem_readdata[7:0], mem_readdata[15:8], mem_readdata[23:16], mem_readdata[31:24]}
             : mem_readdata;
      k      = addr_q[1:0];
      sh_l   = {k, 3'b000};
      sh_r   = {2'd3 - k, 3'b000};
      byte_v = word_w[sh_r +: 8];
      half_v = k[1] ? word_w[15:0] : word_w[31:16];
      case (op_q)
         OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
         OP_LH:   load_val = {{16{half_v[15]}}, half_v};
         OP_LBU:  load_val = {24'd0, byte_v};
         OP_LHU:  load_val = {16'd0, half_v};
         OP_LWL:  load_val = (word_w << sh_l) | (rt_q & ((32'd1 << sh_l) - 32'd1));
         OP_LWR:  load_val = (word_w >> sh_r) | (rt_q & ~(32'hFFFF_FFFF >> sh_r));
         default: load_val = word_w;
      endcase
      case (op_q)
         OP_LB, OP_LBU: be = 4'b0001 << k;
         OP_LH, OP_LHU: be = k[1] ? 4'b1100 : 4'b0011;
         default:       be = 4'b1111;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      rt_d     = rt_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               addr_d  = addr_fix;
               rt_d    = rt_in;
               state_d = trap ? ERR : REQ;
            end
         end
         REQ: begin
            if (!mem_waitrequest) begin
               result_d = load_val;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 3'b000;
         addr_q   <= '0;
         rt_q     <= 32'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         rt_q     <= rt_d;
         result_q <= result_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE) || (state_q == ERR);
   assign result         = result_q;
   assign mem_read       = (state_q == REQ);
   assign mem_address    = mem_read ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_byteenable = mem_read ? be : 4'b0000;

`ifdef LOAD_UNIT_ALIGN_TRAP_EN
   assign addr_err = (state_q == ERR);
`else
   assign addr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// tb_load_unit: directed self-checking bench for load_unit (BYTE_SWAP=1, ADDR_WIDTH=32).
module tb_load_unit;

   logic        clk = 1'b0;
   logic        reset, start, mem_waitrequest;
   logic [2:0]  op;
   logic [31:0] addr, rt_in, mem_readdata;
   logic        busy, done, addr_err, mem_read;
   logic [31:0] result, mem_address;
   logic [3:0]  mem_byteenable;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] rt;
      logic [31:0] rd;
      logic [31:0] exp;
      logic [3:0]  be;
   } vec_t;

   always #5 clk = ~clk;

   load_unit #(.BYTE_SWAP(1), .ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .rt_in(rt_in),
      .busy(busy), .done(done), .result(result), .addr_err(addr_err),
      .mem_address(mem_address), .mem_read(mem_read), .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one load, applies nwait waitrequest cycles, and reports what was observed.
   task automatic run_load(input logic [2:0] l_op, input logic [31:0] l_addr, input logic [31:0] l_rt,
                           input logic [31:0] l_rd, input int nwait,
                           output logic [31:0] res, output logic [3:0] be, output logic [31:0] maddr,
                           output int lat, output logic aerr, output logic rd_seen, output logic done_after);
      int w;
      start = 1'b1; op = l_op; addr = l_addr; rt_in = l_rt;
      mem_readdata = l_rd; mem_waitrequest = 1'b1;
      tick;
      start = 1'b0; lat = 1; w = nwait; rd_seen = 1'b0; be = 4'b0; maddr = 32'd0;
      while (!done && lat < 20) begin
         if (mem_read) begin
            rd_seen = 1'b1; be = mem_byteenable; maddr = mem_address;
         end
         mem_waitrequest = (w > 0);
         if (w > 0) w--;
         tick;
         lat++;
      end
      res = result; aerr = addr_err; mem_waitrequest = 1'b1;
      tick;
      done_after = done;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 3'b000; addr = 32'd0; rt_in = 32'd0;
      mem_waitrequest = 1'b1; mem_readdata = 32'd0;
      repeat (3) tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
      checks++; if (mem_address !== 32'd0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
      checks++; if (mem_byteenable !== 4'd0) begin errors++; $display("FAIL reset_byteenable: got %b expected 0000", mem_byteenable); end
      reset = 1'b0;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %b expected 0", busy); end
   endtask

   task automatic test_lb_latency;
      logic [31:0] res, maddr; logic [3:0] be; int lat; logic aerr, rd, da;
      run_load(3'b000, 32'h1003, 32'd0, 32'h8000_0000, 0, res, be, maddr, lat, aerr, rd, da);
      checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b expected 1000", be); end
      checks++; if (res !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result: got %h expected ffffff80", res); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d expected 2", lat); end
      checks++; if (maddr !== 32'h1000) begin errors++; $display("FAIL lb_address: got %h expected 00001000", maddr); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL lb_done_width: done %b one cycle later, expected 0", da); end
   endtask

   task automatic test_waitrequest;
      logic [31:0] res, maddr; logic [3:0] be; int lat; logic aerr, rd, da;
      // readdata BEEF0000 byte-reversed gives W = 0000EFBE; halfword at k=2 is W[15:0].
      run_load(3'b101, 32'h2002, 32'd0, 32'hBEEF_0000, 3, res, be, maddr, lat, aerr, rd, da);
      checks++; if (be !== 4'b1100) begin errors++; $display("FAIL lhu_be: got %b expected 1100", be); end
      checks++; if (res !== 32'h0000_EFBE) begin errors++; $display("FAIL lhu_result: got %h expected 0000efbe", res); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL lhu_latency: got %0d expected 5", lat); end
   endtask

   task automatic test_formats;
      vec_t vecs [15];
      logic [31:0] res, maddr; logic [3:0] be; int lat; logic aerr, rd, da;
      // 34126587 -> W=87651234 ; 44332211 -> W=11223344
      vecs = '{
         '{3'b001, 32'h100, 32'h0,         32'h3412_6587, 32'hFFFF_8765, 4'b0011},
         '{3'b101, 32'h102, 32'h0,         32'h3412_6587, 32'h0000_1234, 4'b1100},
         '{3'b000, 32'h101, 32'h0,         32'h3412_6587, 32'h0000_0065, 4'b0010},
         '{3'b100, 32'h100, 32'h0,         32'h3412_6587, 32'h0000_0087, 4'b0001},
         '{3'b000, 32'h100, 32'h0,         32'h3412_6587, 32'hFFFF_FF87, 4'b0001},
         '{3'b000, 32'h102, 32'h0,         32'h3412_6587, 32'h0000_0012, 4'b0100},
         '{3'b100, 32'h103, 32'h0,         32'h3412_6587, 32'h0000_0034, 4'b1000},
         '{3'b011, 32'h104, 32'h0,         32'h3412_6587, 32'h8765_1234, 4'b1111},
         '{3'b111, 32'h108, 32'h0,         32'h3412_6587, 32'h8765_1234, 4'b1111},
         '{3'b010, 32'h201, 32'hAABB_CCDD, 32'h4433_2211, 32'h2233_44DD, 4'b1111},
         '{3'b110, 32'h202, 32'hAABB_CCDD, 32'h4433_2211, 32'hAA11_2233, 4'b1111},
         '{3'b010, 32'h200, 32'hAABB_CCDD, 32'h4433_2211, 32'h1122_3344, 4'b1111},
         '{3'b010, 32'h203, 32'hAABB_CCDD, 32'h4433_2211, 32'h44BB_CCDD, 4'b1111},
         '{3'b110, 32'h203, 32'hAABB_CCDD, 32'h4433_2211, 32'h1122_3344, 4'b1111},
         '{3'b110, 32'h200, 32'hAABB_CCDD, 32'h4433_2211, 32'hAABB_CC11, 4'b1111}
      };
      for (int i = 0; i < 15; i++) begin
         run_load(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].rd, i % 2, res, be, maddr, lat, aerr, rd, da);
         checks++;
         if (res !== vecs[i].exp) begin
            errors++; $display("FAIL fmt_result[%0d]: got %h expected %h", i, res, vecs[i].exp);
         end
         checks++;
         if (be !== vecs[i].be) begin
            errors++; $display("FAIL fmt_be[%0d]: got %b expected %b", i, be, vecs[i].be);
         end
         checks++;
         if (maddr !== {vecs[i].addr[31:2], 2'b00}) begin
            errors++; $display("FAIL fmt_address[%0d]: got %h expected %h", i, maddr, {vecs[i].addr[31:2], 2'b00});
         end
      end
   endtask

   task automatic test_misalign;
      logic [31:0] res, maddr; logic [3:0] be; int lat; logic aerr, rd, da;
      // readdata 0DF0FECA -> W = CAFEF00D
`ifdef LOAD_UNIT_ALIGN_TRAP_EN
      logic [31:0] prev;
      prev = result;
      run_load(3'b011, 32'h3001, 32'd0, 32'h0DF0_FECA, 0, res, be, maddr, lat, aerr, rd, da);
      checks++; if (rd !== 1'b0) begin errors++; $display("FAIL trap_no_read: mem_read seen %b expected 0", rd); end
      checks++; if (aerr !== 1'b1) begin errors++; $display("FAIL trap_addr_err: got %b expected 1", aerr); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL trap_latency: got %0d expected 1", lat); end
      checks++; if (res !== prev) begin errors++; $display("FAIL trap_result_held: got %h expected %h", res, prev); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL trap_done_width: done %b one cycle later, expected 0", da); end
      run_load(3'b001, 32'h3003, 32'd0, 32'h0DF0_FECA, 0, res, be, maddr, lat, aerr, rd, da);
      checks++; if (aerr !== 1'b1 || rd !== 1'b0) begin errors++; $display("FAIL trap_lh: addr_err %b read %b expected 1 0", aerr, rd); end
`else
      run_load(3'b011, 32'h3001, 32'd0, 32'h0DF0_FECA, 0, res, be, maddr, lat, aerr, rd, da);
      checks++; if (maddr !== 32'h3000) begin errors++; $display("FAIL align_address: got %h expected 00003000", maddr); end
      checks++; if (res !== 32'hCAFE_F00D) begin errors++; $display("FAIL align_lw_result: got %h expected cafef00d", res); end
      checks++; if (aerr !== 1'b0) begin errors++; $display("FAIL align_addr_err: got %b expected 0", aerr); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL align_latency: got %0d expected 2", lat); end
      run_load(3'b001, 32'h3001, 32'd0, 32'h0DF0_FECA, 0, res, be, maddr, lat, aerr, rd, da);
      checks++; if (res !== 32'hFFFF_CAFE) begin errors++; $display("FAIL align_lh_result: got %h expected ffffcafe", res); end
      checks++; if (be !== 4'b0011) begin errors++; $display("FAIL align_lh_be: got %b expected 0011", be); end
`endif
   endtask

   task automatic test_busy_ignore;
      start = 1'b1; op = 3'b000; addr = 32'h1003; rt_in = 32'd0;
      mem_readdata = 32'h8000_0000; mem_waitrequest = 1'b1;
      tick;
      op = 3'b011; addr = 32'h4000;
      tick;
      checks++; if (mem_byteenable !== 4'b1000 || mem_address !== 32'h1000) begin
         errors++; $display("FAIL busy_req_stable: be %b addr %h expected 1000 00001000", mem_byteenable, mem_address);
      end
      tick;
      checks++; if (busy !== 1'b1 || mem_read !== 1'b1) begin
         errors++; $display("FAIL busy_hold: busy %b mem_read %b expected 1 1", busy, mem_read);
      end
      mem_waitrequest = 1'b0;
      tick;
      checks++; if (done !== 1'b1 || result !== 32'hFFFF_FF80) begin
         errors++; $display("FAIL busy_result: done %b result %h expected 1 ffffff80", done, result);
      end
      start = 1'b0; mem_waitrequest = 1'b1;
      tick;
      tick;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL busy_no_queue: busy %b done %b expected 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] res, maddr; logic [3:0] be; int lat; logic aerr, rd, da;
      logic seen;
      start = 1'b1; op = 3'b011; addr = 32'h5000; rt_in = 32'd0;
      mem_readdata = 32'h1111_1111; mem_waitrequest = 1'b1;
      tick;
      start = 1'b0;
      tick;
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_in_req: mem_read %b expected 1", mem_read); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++;
      if ({busy, done, result, addr_err, mem_read, mem_address, mem_byteenable} !== 71'd0) begin
         errors++; $display("FAIL mid_reset_outputs: busy %b done %b result %h err %b rd %b addr %h be %b expected all 0",
                             busy, done, result, addr_err, mem_read, mem_address, mem_byteenable);
      end
      mem_waitrequest = 1'b0; mem_readdata = 32'hDEAD_BEEF;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (done || busy) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_late_data: activity %b expected 0", seen); end
      run_load(3'b011, 32'h6000, 32'd0, 32'h4433_2211, 1, res, be, maddr, lat, aerr, rd, da);
      checks++; if (res !== 32'h1122_3344 || lat !== 3) begin
         errors++; $display("FAIL mid_recover: result %h latency %0d expected 11223344 3", res, lat);
      end
   endtask

   initial begin
      test_reset;
      test_lb_latency;
      test_waitrequest;
      test_formats;
      test_misalign;
      test_busy_ignore;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
